run_monitor: RTL and testbench

Synthesizable run-control monitor that sits beside `PROCESSOR` and watches its committed-instruction stream. It counts cycles and retired instructions, and declares a halt after a parametrised run of consecutive matching instructions (default: six `32'h0` NOPs). It declares an abort when a cycle limit is exceeded. An optional circular trace buffer holds the most recent committed PCs, for post-mortem on hardware or in simulation.

---
 rtl/run_monitor.sv | 131 +++++++++++++
 tb/tb_run_monitor.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_monitor.sv
// Run-control monitor for the PROCESSOR commit stream: cycle/retire counters, halt on a run of
// matching instructions, abort on a cycle limit. Optional PC trace buffer via RUN_MONITOR_TRACE_EN.
module run_monitor #(
  parameter int          CNT_W       = 32,
  parameter int          HALT_RUN    = 6,
  parameter logic [31:0] HALT_PAT    = 32'h0000_0000,
  parameter logic [31:0] HALT_MASK   = 32'hFFFF_FFFF,
  parameter int          CYCLE_LIMIT = 10000000,
  parameter int          TRACE_DEPTH = 8,
  localparam int         RL_W        = $clog2(HALT_RUN + 1),
  localparam int         IDX_W       = $clog2(TRACE_DEPTH)
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_run,
  input  logic             w_clr,
  input  logic             w_valid,
  input  logic [31:0]      w_pc,
  input  logic [31:0]      w_ir,
  output logic             w_halt,
  output logic             w_abort,
  output logic             w_done,
  output logic [CNT_W-1:0] w_cycle,
  output logic [CNT_W-1:0] w_retired,
  output logic [RL_W-1:0]  w_run_len,
  input  logic [IDX_W-1:0] w_trace_idx,
  output logic [31:0]      w_trace_pc,
  output logic [IDX_W:0]   w_trace_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HALT, ABORT} state_t;

  state_t           state;
  logic             running;
  logic             is_match;
  logic             halt_hit;
  logic             abort_hit;
  logic             advance;
  logic             commit;
  logic [CNT_W-1:0] cycle_nxt;
  logic [CNT_W-1:0] retired_nxt;

  // IDLE with w_run high behaves exactly like a running RUN edge.
  assign running   = w_run && ((state == IDLE) || (state == RUN));
  assign is_match  = (w_ir & HALT_MASK) == (HALT_PAT & HALT_MASK);
  assign halt_hit  = running && w_valid && is_match && (w_run_len == RL_W'(HALT_RUN - 1));
  assign abort_hit = running && !halt_hit && (w_cycle == CNT_W'(CYCLE_LIMIT));
  assign advance   = running && !abort_hit;
  assign commit    = advance && w_valid;

  assign cycle_nxt   = (&w_cycle)   ? w_cycle   : w_cycle + CNT_W'(1);
  assign retired_nxt = (&w_retired) ? w_retired : w_retired + CNT_W'(1);

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state     <= IDLE;
      w_halt    <= 1'b0;
      w_abort   <= 1'b0;
      w_done    <= 1'b0;
      w_cycle   <= '0;
      w_retired <= '0;
      w_run_len <= '0;
    end else if (w_clr) begin
      state     <= IDLE;
      w_halt    <= 1'b0;
      w_abort   <= 1'b0;
      w_done    <= 1'b0;
      w_cycle   <= '0;
      w_retired <= '0;
      w_run_len <= '0;
    end else begin
      if (halt_hit) begin
        state  <= HALT;
        w_halt <= 1'b1;
        w_done <= 1'b1;
      end else if (abort_hit) begin
        state   <= ABORT;
        w_abort <= 1'b1;
        w_done  <= 1'b1;
      end else if (running) begin
        state <= RUN;
      end
      // The halting commit is still counted; the aborting edge counts nothing.
      if (advance) begin
        w_cycle <= cycle_nxt;
        if (w_valid) begin
          w_retired <= retired_nxt;
          w_run_len <= is_match ? w_run_len + RL_W'(1) : '0;
        end
      end
    end
  end

`ifdef RUN_MONITOR_TRACE_EN
  logic [31:0]      trace_mem [TRACE_DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_addr;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wr_ptr      <= '0;
      w_trace_cnt <= '0;
    end else if (w_clr) begin
      wr_ptr      <= '0;
      w_trace_cnt <= '0;
    end else if (commit) begin
      wr_ptr <= wr_ptr + IDX_W'(1);
      if (w_trace_cnt != (IDX_W + 1)'(TRACE_DEPTH)) begin
        w_trace_cnt <= w_trace_cnt + (IDX_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (commit && !w_clr) begin
      trace_mem[wr_ptr] <= w_pc;
    end
  end

  // Newest entry sits just behind the write pointer; depth is a power of two so wrap is free.
  assign rd_addr    = wr_ptr - IDX_W'(1) - w_trace_idx;
  assign w_trace_pc = ({1'b0, w_trace_idx} < w_trace_cnt) ? trace_mem[rd_addr] : 32'h0;
`else
  logic unused_trace;

  assign unused_trace = ^{w_pc, w_trace_idx, commit};
  assign w_trace_pc   = 32'h0;
  assign w_trace_cnt  = '0;
`endif

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: directed scenarios plus randomized commits
// compared every cycle against a queue-based behavioural model.
module tb_run_monitor;

  localparam int          CNT_W       = 32;
  localparam int          HALT_RUN    = 6;
  localparam logic [31:0] HALT_PAT    = 32'h0000_0000;
  localparam logic [31:0] HALT_MASK   = 32'hFFFF_FFFF;
  localparam int          CYCLE_LIMIT = 20;
  localparam int          TRACE_DEPTH = 8;
  localparam int          RL_W        = $clog2(HALT_RUN + 1);
  localparam int          IDX_W       = $clog2(TRACE_DEPTH);

  logic             w_clk;
  logic             w_rst_n;
  logic             w_run;
  logic             w_clr;
  logic             w_valid;
  logic [31:0]      w_pc;
  logic [31:0]      w_ir;
  logic             w_halt;
  logic             w_abort;
  logic             w_done;
  logic [CNT_W-1:0] w_cycle;
  logic [CNT_W-1:0] w_retired;
  logic [RL_W-1:0]  w_run_len;
  logic [IDX_W-1:0] w_trace_idx;
  logic [31:0]      w_trace_pc;
  logic [IDX_W:0]   w_trace_cnt;

  run_monitor #(
    .CNT_W      (CNT_W),
    .HALT_RUN   (HALT_RUN),
    .HALT_PAT   (HALT_PAT),
    .HALT_MASK  (HALT_MASK),
    .CYCLE_LIMIT(CYCLE_LIMIT),
    .TRACE_DEPTH(TRACE_DEPTH)
  ) dut (
    .w_clk      (w_clk),
    .w_rst_n    (w_rst_n),
    .w_run      (w_run),
    .w_clr      (w_clr),
    .w_valid    (w_valid),
    .w_pc       (w_pc),
    .w_ir       (w_ir),
    .w_halt     (w_halt),
    .w_abort    (w_abort),
    .w_done     (w_done),
    .w_cycle    (w_cycle),
    .w_retired  (w_retired),
    .w_run_len  (w_run_len),
    .w_trace_idx(w_trace_idx),
    .w_trace_pc (w_trace_pc),
    .w_trace_cnt(w_trace_cnt)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Model state: plain counts plus histories of committed match flags and PCs.
  int          mCycle;
  int          mRetired;
  bit          mHalt;
  bit          mAbort;
  bit          hist[$];
  logic [31:0] trq[$];

  int nCompared   = 0;
  int nMismatched = 0;

  function automatic int runLen();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (!hist[i]) break;
      n++;
    end
    return n;
  endfunction

  function automatic void modelClear();
    mCycle   = 0;
    mRetired = 0;
    mHalt    = 1'b0;
    mAbort   = 1'b0;
    hist.delete();
    trq.delete();
  endfunction

  function automatic void modelEdge();
    bit nop;
    if (w_clr) begin
      modelClear();
      return;
    end
    if (mHalt || mAbort || !w_run) return;
    nop = w_valid && ((w_ir & HALT_MASK) == (HALT_PAT & HALT_MASK));
    if (nop && (runLen() + 1 == HALT_RUN)) begin
      mHalt = 1'b1;
    end else if (mCycle == CYCLE_LIMIT) begin
      mAbort = 1'b1;
      return;
    end
    mCycle++;
    if (w_valid) begin
      mRetired++;
      hist.push_back(nop);
      if (hist.size() > HALT_RUN) void'(hist.pop_front());
      trq.push_front(w_pc);
      if (trq.size() > TRACE_DEPTH) void'(trq.pop_back());
    end
  endfunction

  function automatic logic [31:0] expTracePc();
`ifdef RUN_MONITOR_TRACE_EN
    if (int'(w_trace_idx) < trq.size()) return trq[w_trace_idx];
`endif
    return 32'h0;
  endfunction

  function automatic int expTraceCnt();
`ifdef RUN_MONITOR_TRACE_EN
    return trq.size();
`else
    return 0;
`endif
  endfunction

  function automatic void checkVal(string name, logic [63:0] act, logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic checkOutput();
    checkVal("halt",      w_halt,      mHalt);
    checkVal("abort",     w_abort,     mAbort);
    checkVal("done",      w_done,      mHalt | mAbort);
    checkVal("cycle",     w_cycle,     mCycle);
    checkVal("retired",   w_retired,   mRetired);
    checkVal("run_len",   w_run_len,   runLen());
    checkVal("trace_cnt", w_trace_cnt, expTraceCnt());
    checkVal("trace_pc",  w_trace_pc,  expTracePc());
  endtask

  task automatic applyStimulus(input bit run, input bit valid, input bit clr,
                               input logic [31:0] ir, input logic [31:0] pc,
                               input logic [IDX_W-1:0] idx);
    w_run       = run;
    w_valid     = valid;
    w_clr       = clr;
    w_ir        = ir;
    w_pc        = pc;
    w_trace_idx = idx;
    @(posedge w_clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic checkAllZero(string tag);
    checkVal({tag, "_halt"},    w_halt,      0);
    checkVal({tag, "_abort"},   w_abort,     0);
    checkVal({tag, "_done"},    w_done,      0);
    checkVal({tag, "_cycle"},   w_cycle,     0);
    checkVal({tag, "_retired"}, w_retired,   0);
    checkVal({tag, "_run_len"}, w_run_len,   0);
    checkVal({tag, "_tcnt"},    w_trace_cnt, 0);
  endtask

  task automatic doReset();
    w_run   = 1'b0;
    w_valid = 1'b0;
    w_clr   = 1'b0;
    w_rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    modelClear();
    #1;
    w_rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ir;
    w_rst_n     = 1'b1;
    w_run       = 1'b0;
    w_clr       = 1'b0;
    w_valid     = 1'b0;
    w_pc        = '0;
    w_ir        = '0;
    w_trace_idx = '0;
    modelClear();
    #1 w_rst_n = 1'b0;
    #1;
    checkAllZero("reset");
    #10 w_rst_n = 1'b1;

    $display("[TB] basic halt");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 32'h1000 + i, 32'(i * 4), 0);
    for (int i = 0; i < 6; i++) begin
      checkVal("basic_no_early_halt", w_halt, 0);
      applyStimulus(1, 1, 0, 32'h0, 32'(12 + i * 4), 0);
    end
    checkVal("basic_halt", w_halt, 1);
    checkVal("basic_retired", w_retired, 9);
    checkVal("basic_cycle", w_cycle, 9);
    for (int i = 0; i < 2; i++) applyStimulus(1, 1, 0, 32'h77, 32'h100, 0);
    checkVal("basic_cycle_frozen", w_cycle, 9);

    $display("[TB] clear from halt");
    applyStimulus(1, 1, 1, 32'h0, 32'h0, 0);
    checkAllZero("clr_halt");

    $display("[TB] broken run");
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 32'h0, 32'(i * 4), 0);
    applyStimulus(1, 1, 0, 32'h2408_0001, 32'h14, 0);
    checkVal("broken_len_zero", w_run_len, 0);
    for (int i = 0; i < 6; i++) begin
      checkVal("broken_no_halt", w_halt, 0);
      applyStimulus(1, 1, 0, 32'h0, 32'(24 + i * 4), 0);
    end
    checkVal("broken_halt", w_halt, 1);

    $display("[TB] bubbles");
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 0);
    applyStimulus(1, 1, 0, 32'h0, 32'h0, 0);
    applyStimulus(1, 1, 0, 32'h0, 32'h4, 0);
    applyStimulus(1, 0, 0, 32'h5, 32'h8, 0);
    checkVal("bubble_len_hold", w_run_len, 2);
    applyStimulus(1, 1, 0, 32'h0, 32'h8, 0);
    checkVal("bubble_len_inc", w_run_len, 3);

    $display("[TB] abort");
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 0);
    for (int i = 0; i < 21; i++) applyStimulus(1, 1, 0, 32'h1 + 32'(i), 32'(i * 4), 0);
    checkVal("abort_flag", w_abort, 1);
    checkVal("abort_cycle", w_cycle, 20);
    checkVal("abort_no_halt", w_halt, 0);
    checkVal("abort_done", w_done, 1);
    applyStimulus(1, 1, 0, 32'h0, 32'h0, 0);
    checkVal("abort_cycle_frozen", w_cycle, 20);

    $display("[TB] tie-break");
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 0);
    for (int i = 0; i < 15; i++) applyStimulus(1, 1, 0, 32'h9, 32'(i * 4), 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 32'h0, 32'(60 + i * 4), 0);
    checkVal("tie_halt", w_halt, 1);
    checkVal("tie_abort", w_abort, 0);

    $display("[TB] trace");
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, 1, 0, 32'h33, 32'(i * 4), 0);
    w_trace_idx = 3'd0;
    #1;
`ifdef RUN_MONITOR_TRACE_EN
    checkVal("trace_cnt8", w_trace_cnt, 8);
    checkVal("trace_idx0", w_trace_pc, 32'h2C);
    w_trace_idx = 3'd7;
    #1;
    checkVal("trace_idx7", w_trace_pc, 32'h10);
`else
    checkVal("trace_cnt_off", w_trace_cnt, 0);
    checkVal("trace_idx0_off", w_trace_pc, 0);
    w_trace_idx = 3'd7;
    #1;
    checkVal("trace_idx7_off", w_trace_pc, 0);
`endif

    $display("[TB] random");
    for (int i = 0; i < 1500; i++) begin
      bit clr;
      clr = (mHalt || mAbort) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
      ir  = ($urandom_range(0, 3) != 0) ? 32'h0 : $urandom;
      applyStimulus($urandom_range(0, 6) != 0, $urandom_range(0, 4) != 0, clr, ir,
                    $urandom, IDX_W'($urandom_range(0, TRACE_DEPTH - 1)));
    end

    $display("[TB] async reset mid-run");
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 32'h0, 32'(i * 4), 0);
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 32'h5, 32'(i * 4), 0);
    checkVal("post_reset_cycle", w_cycle, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
